// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences PC/IR/ALU/unified memory over 3-5 cycles.
// Optional macro MCTRL_ILLEGAL_TRAP_EN: unsupported opcodes halt and raise illegal_o.
module multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [5:0] instr_op_i,
   input  logic       zero_i,
   input  logic       mem_ready_i,
   output logic       pc_write_o,
   output logic       ir_write_o,
   output logic       iord_o,
   output logic       mem_read_o,
   output logic       mem_write_o,
   output logic       reg_write_o,
   output logic [1:0] reg_dst_o,
   output logic [1:0] mem2reg_o,
   output logic       alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic [2:0] alu_op_o,
   output logic [1:0] pc_src_o,
   output logic       instr_done_o,
   output logic       mem_err_o,
`ifdef MCTRL_ILLEGAL_TRAP_EN
   output logic       illegal_o,
`endif
   output logic [3:0] state_o
);

   localparam int unsigned CNT_W = 8;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_SLTI = 6'b001010;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,  FETCH  = 4'd1,  DECODE = 4'd2,  MEM_ADDR = 4'd3,
      MEM_RD   = 4'd4,  MEM_WB = 4'd5,  MEM_WR = 4'd6,  R_EXE    = 4'd7,
      R_WB     = 4'd8,  I_EXE  = 4'd9,  I_WB   = 4'd10, BRANCH   = 4'd11,
      JUMP     = 4'd12, JAL    = 4'd13, HALT   = 4'd14
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] wait_cnt;
   logic             mem_err;
   logic             wait_st_c;
   logic             timeout_c;
   logic             illegal_set_c;

   // Timeout fires on the wait cycle that would bring the count up to MEM_TIMEOUT.
   assign wait_st_c = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
   assign timeout_c = (MEM_TIMEOUT != 0) && wait_st_c && !mem_ready_i &&
                      ((9'(wait_cnt) + 9'd1) == 9'(MEM_TIMEOUT));

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state    <= IDLE;
         wait_cnt <= '0;
         mem_err  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (timeout_c)
            mem_err <= 1'b1;
         if ((state_nxt != state) &&
             ((state_nxt == FETCH) || (state_nxt == MEM_RD) || (state_nxt == MEM_WR)))
            wait_cnt <= '0;
         else if (wait_st_c && !mem_ready_i && (wait_cnt != '1))
            wait_cnt <= wait_cnt + CNT_W'(1);
      end
   end

`ifdef MCTRL_ILLEGAL_TRAP_EN
   logic illegal;
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)
         illegal <= 1'b0;
      else if (illegal_set_c)
         illegal <= 1'b1;
   end
   assign illegal_o = illegal;
`endif

   // Next-state and Moore output decode; mem_ready_i/zero_i only gate enables.
   always_comb begin
      state_nxt     = state;
      illegal_set_c = 1'b0;
      pc_write_o    = 1'b0;
      ir_write_o    = 1'b0;
      iord_o        = 1'b0;
      mem_read_o    = 1'b0;
      mem_write_o   = 1'b0;
      reg_write_o   = 1'b0;
      reg_dst_o     = 2'b00;
      mem2reg_o     = 2'b00;
      alu_src_a_o   = 1'b0;
      alu_src_b_o   = 2'b00;
      alu_op_o      = 3'b000;
      pc_src_o      = 2'b00;
      instr_done_o  = 1'b0;
      case (state)
         IDLE: state_nxt = FETCH;
         FETCH: begin
            mem_read_o  = 1'b1;
            alu_src_b_o = 2'b01;
            alu_op_o    = 3'b100;
            pc_write_o  = mem_ready_i;
            ir_write_o  = mem_ready_i;
            if (mem_ready_i) state_nxt = DECODE;
         end
         DECODE: begin
            alu_src_b_o = 2'b11;
            alu_op_o    = 3'b100;
            casez (instr_op_i)
               6'b000000:             state_nxt = R_EXE;
               6'b100011, 6'b101011:  state_nxt = MEM_ADDR;
               6'b000100:             state_nxt = BRANCH;
               6'b001???:             state_nxt = I_EXE;
               6'b000010:             state_nxt = JUMP;
               6'b000011:             state_nxt = JAL;
`ifdef MCTRL_ILLEGAL_TRAP_EN
               default: begin
                  state_nxt     = HALT;
                  illegal_set_c = 1'b1;
               end
`else
               default:               state_nxt = FETCH;
`endif
            endcase
         end
         MEM_ADDR: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'b10;
            alu_op_o    = 3'b100;
            state_nxt   = (instr_op_i == OP_SW) ? MEM_WR : MEM_RD;
         end
         MEM_RD: begin
            iord_o     = 1'b1;
            mem_read_o = 1'b1;
            if (mem_ready_i) state_nxt = MEM_WB;
         end
         MEM_WB: begin
            reg_write_o  = 1'b1;
            mem2reg_o    = 2'b01;
            instr_done_o = 1'b1;
            state_nxt    = FETCH;
         end
         MEM_WR: begin
            iord_o       = 1'b1;
            mem_write_o  = 1'b1;
            instr_done_o = mem_ready_i;
            if (mem_ready_i) state_nxt = FETCH;
         end
         R_EXE: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = 3'b010;
            state_nxt   = R_WB;
         end
         R_WB: begin
            reg_write_o  = 1'b1;
            reg_dst_o    = 2'b01;
            instr_done_o = 1'b1;
            state_nxt    = FETCH;
         end
         I_EXE: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'b10;
            alu_op_o    = (instr_op_i == OP_SLTI) ? 3'b111 : 3'b100;
            state_nxt   = I_WB;
         end
         I_WB: begin
            reg_write_o  = 1'b1;
            instr_done_o = 1'b1;
            state_nxt    = FETCH;
         end
         BRANCH: begin
            alu_src_a_o  = 1'b1;
            alu_op_o     = 3'b101;
            pc_src_o     = 2'b01;
            pc_write_o   = zero_i;
            instr_done_o = 1'b1;
            state_nxt    = FETCH;
         end
         JUMP: begin
            pc_write_o   = 1'b1;
            pc_src_o     = 2'b10;
            instr_done_o = 1'b1;
            state_nxt    = FETCH;
         end
         JAL: begin
            pc_write_o   = 1'b1;
            pc_src_o     = 2'b10;
            reg_write_o  = 1'b1;
            reg_dst_o    = 2'b10;
            mem2reg_o    = 2'b10;
            instr_done_o = 1'b1;
            state_nxt    = FETCH;
         end
         HALT:    state_nxt = HALT;
         default: state_nxt = IDLE;
      endcase
      if (timeout_c)
         state_nxt = HALT;
   end

   assign mem_err_o = mem_err;
   assign state_o   = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: latency table, random instruction
// stream against a per-instruction cycle-trace model, reset and timeout cases.
module tb_multicycle_ctrl;

   localparam int unsigned TMO = 4;

   logic clk = 1'b0;
   logic rst_i;
   logic [5:0] instr_op;
   logic zero, mem_ready;
   logic pc_write, ir_write, iord, mem_read, mem_write, reg_write;
   logic [1:0] reg_dst, mem2reg, alu_src_b, pc_src;
   logic alu_src_a, instr_done, mem_err;
   logic [2:0] alu_op;
   logic [3:0] state_o;
`ifdef MCTRL_ILLEGAL_TRAP_EN
   logic illegal;
`endif

   multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
      .clk_i(clk), .rst_i(rst_i), .instr_op_i(instr_op), .zero_i(zero),
      .mem_ready_i(mem_ready), .pc_write_o(pc_write), .ir_write_o(ir_write),
      .iord_o(iord), .mem_read_o(mem_read), .mem_write_o(mem_write),
      .reg_write_o(reg_write), .reg_dst_o(reg_dst), .mem2reg_o(mem2reg),
      .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op),
      .pc_src_o(pc_src), .instr_done_o(instr_done), .mem_err_o(mem_err),
`ifdef MCTRL_ILLEGAL_TRAP_EN
      .illegal_o(illegal),
`endif
      .state_o(state_o));

   always #5 clk = ~clk;

   logic [19:0] dut_o;
   assign dut_o = {pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
                   mem2reg, alu_src_a, alu_src_b, alu_op, pc_src, instr_done, mem_err};

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // ---------------- latency table ----------------
   typedef struct {
      logic [5:0] op; logic z; int fw; int mw;
      int cyc; int dn; int pw; int rw;
   } tab_t;
   tab_t tab[12];

   task automatic run_tab(input tab_t t, input int idx);
      int cyc = 0, dn = 0, pw = 0, rw = 0, fwc = 0, mwc = 0;
      bit left = 0, ended = 0;
      instr_op = t.op;
      zero     = t.z;
      for (int k = 0; k < 40 && !ended; k++) begin
         @(negedge clk);
         if (state_o == 4'd1) begin
            mem_ready = (fwc >= t.fw);
            if (!mem_ready) fwc++;
         end else if (state_o == 4'd4 || state_o == 4'd6) begin
            mem_ready = (mwc >= t.mw);
            if (!mem_ready) mwc++;
         end else
            mem_ready = 1'b1;
         #1;
         cyc++;
         dn += int'(instr_done);
         pw += int'(pc_write);
         rw += int'(reg_write);
         @(posedge clk); #1;
         if (state_o != 4'd1) left = 1;
         else if (left) ended = 1;
      end
      chk($sformatf("tab%0d_end", idx), 32'(ended), 32'd1);
      chk($sformatf("tab%0d_cycles", idx), 32'(cyc), 32'(t.cyc));
      chk($sformatf("tab%0d_done", idx), 32'(dn), 32'(t.dn));
      chk($sformatf("tab%0d_pcw", idx), 32'(pw), 32'(t.pw));
      chk($sformatf("tab%0d_regw", idx), 32'(rw), 32'(t.rw));
   endtask

   // ---------------- cycle-trace reference model ----------------
   typedef struct {
      logic [5:0] op; logic z; logic rdy; logic [3:0] st; logic [19:0] o;
   } cyc_t;
   cyc_t q[$];
   logic [5:0] cur_op;
   logic cur_z;

   function automatic logic [19:0] ov(input logic pcw, irw, io, mrd, mwr, rw,
                                      input logic [1:0] rdst, m2r, input logic asa,
                                      input logic [1:0] asb, input logic [2:0] aop,
                                      input logic [1:0] psrc, input logic done);
      return {pcw, irw, io, mrd, mwr, rw, rdst, m2r, asa, asb, aop, psrc, done, 1'b0};
   endfunction

   task automatic push(input logic [3:0] st, input logic rdy, input logic [19:0] o);
      cyc_t c;
      c.op = cur_op; c.z = cur_z; c.rdy = rdy; c.st = st; c.o = o;
      q.push_back(c);
   endtask

   // Expand one instruction into its expected per-cycle trace.
   task automatic model_instr(input logic [5:0] op, input logic z, input int fw, input int mw);
      logic r;
      cur_op = op; cur_z = z;
      for (int i = 0; i <= fw; i++) begin
         r = (i == fw);
         push(4'd1, r, ov(r, r, 0, 1, 0, 0, 2'b00, 2'b00, 0, 2'b01, 3'b100, 2'b00, 0));
      end
      push(4'd2, 1'($urandom), ov(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 3'b100, 2'b00, 0));
      if (op == 6'b000000) begin
         push(4'd7, 1'($urandom), ov(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 3'b010, 2'b00, 0));
         push(4'd8, 1'($urandom), ov(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 0, 2'b00, 3'b000, 2'b00, 1));
      end else if (op == 6'b100011 || op == 6'b101011) begin
         push(4'd3, 1'($urandom), ov(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 3'b100, 2'b00, 0));
         for (int i = 0; i <= mw; i++) begin
            r = (i == mw);
            if (op == 6'b100011)
               push(4'd4, r, ov(0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 2'b00, 0));
            else
               push(4'd6, r, ov(0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 2'b00, r));
         end
         if (op == 6'b100011)
            push(4'd5, 1'($urandom), ov(0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0, 2'b00, 3'b000, 2'b00, 1));
      end else if (op == 6'b000100)
         push(4'd11, 1'($urandom), ov(z, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 3'b101, 2'b01, 1));
      else if (op[5:3] == 3'b001) begin
         push(4'd9, 1'($urandom), ov(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10,
                                     (op == 6'b001010) ? 3'b111 : 3'b100, 2'b00, 0));
         push(4'd10, 1'($urandom), ov(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00, 3'b000, 2'b00, 1));
      end else if (op == 6'b000010)
         push(4'd12, 1'($urandom), ov(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 2'b10, 1));
      else if (op == 6'b000011)
         push(4'd13, 1'($urandom), ov(1, 0, 0, 0, 0, 1, 2'b10, 2'b10, 0, 2'b00, 3'b000, 2'b10, 1));
   endtask

   task automatic run_q();
      cyc_t r;
      while (q.size() > 0) begin
         r = q.pop_front();
         @(negedge clk);
         instr_op = r.op; zero = r.z; mem_ready = r.rdy;
         #1;
         chk("rand_state", 32'(state_o), 32'(r.st));
         chk("rand_outs", 32'(dut_o), 32'(r.o));
      end
   endtask

   task automatic reset_cycle();
      @(negedge clk); rst_i = 1'b0;
      #1;
      chk("rst_state", 32'(state_o), 32'd0);
      chk("rst_outs", 32'(dut_o), 32'd0);
      @(negedge clk); rst_i = 1'b1;
      #1;
      chk("post_rst_idle", 32'(state_o), 32'd0);
      @(posedge clk); #1;
      chk("post_rst_fetch", 32'(state_o), 32'd1);
   endtask

   logic [5:0] ops[12] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b001010,
                           6'b001111, 6'b000010, 6'b000011, 6'b111111, 6'b000001, 6'b100011};

   initial begin
      bit found, bad_wr;
      int rdcnt;
      tab[0]  = '{6'b000000, 0, 0, 0, 4, 1, 1, 1};
      tab[1]  = '{6'b100011, 0, 0, 3, 8, 1, 1, 1};
      tab[2]  = '{6'b100011, 1, 0, 0, 5, 1, 1, 1};
      tab[3]  = '{6'b101011, 0, 0, 2, 6, 1, 1, 0};
      tab[4]  = '{6'b000100, 1, 0, 0, 3, 1, 2, 0};
      tab[5]  = '{6'b000100, 0, 0, 0, 3, 1, 1, 0};
      tab[6]  = '{6'b000010, 0, 0, 0, 3, 1, 2, 0};
      tab[7]  = '{6'b000011, 0, 0, 0, 3, 1, 2, 1};
      tab[8]  = '{6'b001000, 1, 2, 0, 6, 1, 1, 1};
      tab[9]  = '{6'b001010, 0, 0, 0, 4, 1, 1, 1};
      tab[10] = '{6'b111111, 0, 0, 0, 2, 0, 1, 0};
      tab[11] = '{6'b101011, 1, 3, 3, 10, 1, 1, 0};

      rst_i = 1'b0; instr_op = '0; zero = 1'b0; mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", 32'(state_o), 32'd0);
      chk("reset_outs", 32'(dut_o), 32'd0);
      @(negedge clk); rst_i = 1'b1;
      #1;
      chk("rel_idle", 32'(state_o), 32'd0);
      @(posedge clk); #1;
      chk("rel_fetch", 32'(state_o), 32'd1);

      foreach (tab[i]) run_tab(tab[i], i);

      // Reset asserted while in MEM_RD with memory always ready.
      instr_op = 6'b100011; mem_ready = 1'b1; found = 0;
      for (int k = 0; k < 10 && !found; k++) begin
         @(negedge clk);
         if (state_o == 4'd4) found = 1;
      end
      chk("memrd_reached", 32'(found), 32'd1);
      rst_i = 1'b0;
      #1;
      chk("midrst_state", 32'(state_o), 32'd0);
      chk("midrst_outs", 32'(dut_o), 32'd0);
      @(posedge clk); #1;
      chk("midrst_hold", 32'(dut_o), 32'd0);
      @(negedge clk); rst_i = 1'b1;
      #1;
      chk("midrst_idle", 32'(state_o), 32'd0);
      @(posedge clk); #1;
      chk("midrst_fetch", 32'(state_o), 32'd1);

      for (int n = 0; n < 40; n++) begin
         model_instr(ops[$urandom_range(0, 11)], 1'($urandom),
                     int'($urandom_range(0, TMO - 1)), int'($urandom_range(0, TMO - 1)));
         run_q();
      end

      // Fetch timeout: memory never answers.
      bad_wr = 0;
      for (int k = 0; k < int'(TMO); k++) begin
         @(negedge clk); mem_ready = 1'b0;
         #1;
         if (pc_write || ir_write) bad_wr = 1;
         chk("tmo_in_fetch", 32'(state_o), 32'd1);
      end
      chk("tmo_no_pc_ir_write", 32'(bad_wr), 32'd0);
      @(posedge clk); #1;
      chk("tmo_halt", 32'(state_o), 32'd14);
      chk("tmo_err", 32'(mem_err), 32'd1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); mem_ready = 1'b1; instr_op = 6'b000011;
         #1;
         chk("halt_stays", 32'(state_o), 32'd14);
         chk("halt_outs", 32'(dut_o), 32'd1);
      end
      reset_cycle();
      chk("err_cleared", 32'(mem_err), 32'd0);

      // MEM_RD timeout: lw whose read never completes.
      instr_op = 6'b100011; rdcnt = 0; found = 0; bad_wr = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         mem_ready = (state_o != 4'd4);
         #1;
         if (state_o == 4'd4) rdcnt++;
         if (reg_write) bad_wr = 1;
         @(posedge clk); #1;
         if (state_o == 4'd14) found = 1;
      end
      chk("rdtmo_halt", 32'(found), 32'd1);
      chk("rdtmo_cycles", 32'(rdcnt), 32'(TMO));
      chk("rdtmo_err", 32'(mem_err), 32'd1);
      chk("rdtmo_no_regw", 32'(bad_wr), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the MIPS CPU datapath.
- Sequences one instruction over 3–5 cycles through the shared PC, IR, ALU and single unified memory.
- Handshakes with memory through mem_ready_i.
- ALU op and mux encodings match the single-cycle control scheme, so the existing ALU_Ctrl, register file and muxes are reused unchanged.

Parameters:
- MEM_TIMEOUT, 16: max cycles spent waiting for mem_ready_i in any memory state before error; 0 disables the timeout; valid range 0–255.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- instr_op_i  in  6  opcode from the IR, instr[31:26]
- zero_i  in  1  ALU zero flag
- mem_ready_i  in  1  memory access completes this cycle
- pc_write_o  out  1  PC load enable
- ir_write_o  out  1  IR load enable
- iord_o  out  1  memory address select: 0=PC, 1=ALUOut
- mem_read_o  out  1  memory read request
- mem_write_o  out  1  memory write request
- reg_write_o  out  1  register file write enable
- reg_dst_o  out  2  write register select: 00=rt, 01=rd, 10=$31
- mem2reg_o  out  2  write-back data select: 00=ALUOut, 01=MDR, 10=PC
- alu_src_a_o  out  1  ALU A select: 0=PC, 1=rs
- alu_src_b_o  out  2  ALU B select: 00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- alu_op_o  out  3  100=add, 101=sub, 010=R-type funct, 111=slt
- pc_src_o  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
- instr_done_o  out  1  one-cycle pulse in the final cycle of each instruction
- mem_err_o  out  1  sticky memory timeout flag
- state_o  out  4  current state, for debug

Behaviour:
- All outputs are a Moore decode of the registered state; the only exceptions are the gating terms stated below.
- Reset (rst_i=0, asynchronous) forces:
  - state=IDLE
  - wait counter=0, mem_err_o=0
  - every output 0
- Reset asserted mid-instruction aborts it; nothing is written on the cycle reset is asserted.
- States: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, R_EXE=7, R_WB=8, I_EXE=9, I_WB=10, BRANCH=11, JUMP=12, JAL=13, HALT=14.
- IDLE: always moves to FETCH on the next cycle.
- FETCH:
  - Outputs: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=100, pc_src=00.
  - pc_write_o = ir_write_o = mem_ready_i.
  - Stays in FETCH until mem_ready_i=1, then goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=100 (branch target into ALUOut). Next state by opcode:
  - 000000 → R_EXE
  - 100011 (lw) or 101011 (sw) → MEM_ADDR
  - 000100 (beq) → BRANCH
  - 001xxx → I_EXE
  - 000010 (j) → JUMP
  - 000011 (jal) → JAL
  - anything else → FETCH (treated as NOP)
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=100; goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: iord=1, mem_read=1; waits for mem_ready_i, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem2reg=01, instr_done=1; then FETCH.
- MEM_WR: iord=1, mem_write=1; waits for mem_ready_i; instr_done = mem_ready_i; then FETCH.
- R_EXE: alu_src_a=1, alu_src_b=00, alu_op=010; then R_WB.
- R_WB: reg_write=1, reg_dst=01, mem2reg=00, instr_done=1; then FETCH.
- I_EXE: alu_src_a=1, alu_src_b=10; alu_op=111 if opcode=001010 (slti), else 100; then I_WB.
- I_WB: reg_write=1, reg_dst=00, mem2reg=00, instr_done=1; then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=101, pc_src=01, pc_write = zero_i, instr_done=1; then FETCH.
- JUMP: pc_write=1, pc_src=10, instr_done=1; then FETCH.
- JAL: pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem2reg=10 (PC already holds PC+4), instr_done=1; then FETCH.
- Resulting latencies with zero-wait memory: beq/j/jal 3 cycles; R-type, I-type and sw 4; lw 5. Each wait cycle adds one.
- Wait counter (8 bits):
  - Cleared on entry to FETCH, MEM_RD or MEM_WR.
  - Increments on each cycle in those states with mem_ready_i=0, saturating at 255.
  - If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT, set mem_err_o=1 and go to HALT.
- HALT: all enables 0; stays in HALT until reset. mem_err_o is cleared only by reset.
- Request outputs (mem_read_o, mem_write_o, iord_o) hold stable for the whole wait period.

Optional Feature:
- Macro MCTRL_ILLEGAL_TRAP_EN.
- Defined: an unsupported opcode in DECODE goes to HALT and asserts the extra output port illegal_o (1 bit, sticky, cleared by reset). mem_err_o is unaffected.
- Undefined: illegal_o is absent and unsupported opcodes behave as a NOP (DECODE → FETCH, no instr_done pulse).

Test Plan:
- Reset mid-MEM_RD, mem_ready_i tied to 1 → state_o=0 and all outputs 0 during reset; after release: IDLE, FETCH, then normal operation.
- R-type (000000), mem_ready_i=1 → state sequence 1,2,7,8,1; reg_write=1 and reg_dst=01 only in state 8; instr_done pulses once.
- lw (100011) with mem_ready_i low for 3 cycles in MEM_RD → MEM_RD lasts 4 cycles with iord=1 and mem_read=1 held; total 8 cycles; MEM_WB sets mem2reg=01.
- beq (000100) with zero_i=1, then again with zero_i=0 → pc_write=1 in BRANCH only when zero_i=1; pc_src=01, alu_op=101 in both cases.
- jal (000011) → 3 cycles; JAL state outputs reg_dst=10, mem2reg=10, pc_src=10, pc_write=1.
- MEM_TIMEOUT=4, mem_ready_i held 0 in FETCH → mem_err_o=1 after 4 wait cycles, state_o=14; pc_write and ir_write never asserted.
